cw_stream_encoder: RTL and testbench
====================================

CW_STREAM_ENCODER -- requirements
Module: cw_stream_encoder

Interface
REQ-001 Parameter N, default 18: codeword length in bits.
REQ-002 Parameter W, default 9: codeword Hamming weight, 1 <= W < N.
REQ-003 Parameter K, default 15: message bits per codeword; 2^K <= C(N,W) SHALL hold, checked at elaboration.
REQ-004 Parameter BYTE_W, default 8: input word width.
REQ-005 Parameter FIFO_DEPTH, default 4: input words buffered, power of two.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_b  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle job start pulse.
REQ-009 num_words  in  8  codewords in the job, sampled on start.
REQ-010 msg_byte  in  BYTE_W  message data.
REQ-011 wr_en  in  1  write msg_byte into the FIFO.
REQ-012 wr_full  out  1  FIFO full.
REQ-013 cw_ack  in  1  consumer accepts cw_out.
REQ-014 cw_out  out  N  constant-weight codeword.
REQ-015 cw_rdy  out  1  cw_out valid.
REQ-016 cw_done  out  1  one-cycle pulse when the job completes.
REQ-017 busy  out  1  job in progress.

Function
REQ-018 FIFO: BYTE_W wide, FIFO_DEPTH deep; wr_en while wr_full is dropped without corrupting contents.
REQ-019 Serializer: delivers FIFO data one bit per cycle, LSB first; bits not consumed by one codeword carry over to the next codeword.
REQ-020 FSM states are IDLE, LOAD, ENC, OUT and DONE.
REQ-021 IDLE -> LOAD on start with num_words != 0; start with num_words == 0 -> DONE; start outside IDLE is ignored.
REQ-022 LOAD: shifts K bits into m, LSB first, one per cycle while a bit is available; stalls (holds state) when the FIFO and serializer are empty; -> ENC after the K-th bit.
REQ-023 ENC: N cycles, i = N-1 down to 0, w initialised to W; if w > 0 and m >= C(i,w): cw[i] = 1, m -= C(i,w), w -= 1; else cw[i] = 0. C(i,w) = 0 for i < w.
REQ-024 Binomials: computed by a constant function at elaboration, not at run time; datapath width is ceil(log2 C(N,W)).
REQ-025 OUT: cw_rdy = 1 with cw_out stable until cw_ack is sampled high; then -> LOAD if words remain, else -> DONE.
REQ-026 DONE: cw_done = 1 for exactly one cycle, busy = 0, -> IDLE.
REQ-027 busy is 1 in LOAD, ENC and OUT.
REQ-028 Minimum latency from the first available bit to cw_rdy is K + N cycles.
REQ-029 cw_ack outside OUT is ignored; wr_en is accepted in every state.
REQ-030 Every cw_out SHALL have weight exactly W; the mapping m -> cw_out is injective.

Reset
REQ-031 rst_b low asynchronously clears the FIFO, serializer, counters, m, and the FSM (to IDLE); outputs reset to cw_out = 0, cw_rdy = 0, cw_done = 0, busy = 0, wr_full = 0.
REQ-032 Reset mid-job abandons the job; no cw_done is produced.

Configuration
REQ-033 With macro CW_WEIGHT_CHECK_EN defined, an extra output weight_err (1 bit) SHALL be present: registered popcount(cw_out) != W, valid with cw_rdy, reset 0.
REQ-034 Without CW_WEIGHT_CHECK_EN, the port and its logic are absent.

Verification
REQ-035 Defaults; write bytes 0x00, 0x00; start with num_words = 1 -> cw_out = 0x001FF, cw_rdy, then cw_done after cw_ack.
REQ-036 Bytes 0x01, 0x00 -> m = 1 -> cw_out = 0x002FF.
REQ-037 Bytes 0xFF, 0x7F (m = 32767) -> weight 9; hold cw_ack low for 10 cycles -> cw_out and cw_rdy stay stable.
REQ-038 num_words = 3 with only 2 bytes written -> first word produced, FSM stalls in LOAD; 4 more bytes written -> words 2 and 3 produced, a single cw_done.
REQ-039 5 writes with no reads (FIFO_DEPTH = 4) -> wr_full after the 4th write, 5th write dropped; num_words = 0 start -> cw_done the next cycle.
REQ-040 rst_b pulsed during ENC -> all outputs 0 immediately, FIFO empty; a new job afterwards matches the reference model.

Source files
------------

// File: rtl/cw_stream_encoder_if.sv
// Handshake bundle for cw_stream_encoder: message write port, job control and codeword output.
// Carries weight_err only when CW_WEIGHT_CHECK_EN is defined.
interface cw_stream_encoder_if #(
  parameter int unsigned N      = 18,
  parameter int unsigned BYTE_W = 8
);
  logic              start;
  logic [7:0]        num_words;
  logic [BYTE_W-1:0] msg_byte;
  logic              wr_en;
  logic              wr_full;
  logic              cw_ack;
  logic [N-1:0]      cw_out;
  logic              cw_rdy;
  logic              cw_done;
  logic              busy;
`ifdef CW_WEIGHT_CHECK_EN
  logic              weight_err;
`endif

  modport master (
    output start, num_words, msg_byte, wr_en, cw_ack,
    input  wr_full, cw_out, cw_rdy, cw_done, busy
`ifdef CW_WEIGHT_CHECK_EN
    , input weight_err
`endif
  );

  modport slave (
    input  start, num_words, msg_byte, wr_en, cw_ack,
    output wr_full, cw_out, cw_rdy, cw_done, busy
`ifdef CW_WEIGHT_CHECK_EN
    , output weight_err
`endif
  );
endinterface

// File: rtl/cw_stream_encoder.sv
// Byte stream -> K-bit messages -> constant-weight N-bit codewords (combinatorial number system).
// Optional CW_WEIGHT_CHECK_EN adds a registered weight_err flag on the interface.
module cw_stream_encoder #(
  parameter int unsigned N          = 18,
  parameter int unsigned W          = 9,
  parameter int unsigned K          = 15,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  cw_stream_encoder_if.slave bus
);
  function automatic longint unsigned binom(input int unsigned n, input int unsigned k);
    longint unsigned r;
    r = 1;
    if (k > n) return 0;
    for (int unsigned j = 0; j < k; j++) r = (r * 64'(n - j)) / 64'(j + 1);
    return r;
  endfunction

  localparam longint unsigned CNW = binom(N, W);
  localparam int unsigned MW = $clog2(CNW);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned WW = $clog2(W + 1);
  localparam int unsigned BW = $clog2(K + 1);
  localparam int unsigned SW = $clog2(BYTE_W + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  if ((64'd1 << K) > CNW || W == 0 || W >= N || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("cw_stream_encoder: invalid parameter set");
  end

  // Table entries above the datapath range saturate; such coefficients always exceed m.
  logic [MW-1:0] ctab [N][W+1];
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gw = 0; gw <= W; gw++) begin : g_col
      localparam longint unsigned BV = binom(gi, gw);
      localparam logic [MW-1:0] CV = (BV >= (64'd1 << MW)) ? '1 : MW'(BV);
      assign ctab[gi][gw] = CV;
    end
  end

  typedef enum logic [2:0] {IDLE, LOAD, ENC, OUT, DONE} state_t;
  state_t state_q, state_d;

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [BYTE_W-1:0] sr, head;
  logic [SW-1:0]     sr_cnt;
  logic              full, empty, push, pop, take, bit_avail, cur_bit;

  logic [MW-1:0] m, coef;
  logic [IW-1:0] i_cnt;
  logic [WW-1:0] w_cnt;
  logic [BW-1:0] bit_cnt;
  logic [7:0]    words_left;
  logic [N-1:0]  cw_q;
  logic          enc_one;

  always_comb begin
    head      = mem[rd_ptr];
    full      = (count == (PW+1)'(FIFO_DEPTH));
    empty     = (count == '0);
    push      = bus.wr_en && !full;
    bit_avail = (sr_cnt != '0) || !empty;
    cur_bit   = (sr_cnt != '0) ? sr[0] : head[0];
    take      = (state_q == LOAD) && bit_avail;
    pop       = take && (sr_cnt == '0);
    coef      = ctab[i_cnt][w_cnt];
    enc_one   = (w_cnt != '0) && (m >= coef);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.msg_byte;
  end

  // With an empty serializer the FIFO head is consumed directly, so bits stream without bubbles.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sr     <= '0;
      sr_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (take) begin
        if (sr_cnt != '0) begin
          sr     <= sr >> 1;
          sr_cnt <= sr_cnt - 1'b1;
        end else begin
          sr     <= head >> 1;
          sr_cnt <= SW'(BYTE_W - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.num_words != 8'd0) ? LOAD : DONE;
      LOAD: if (take && bit_cnt == BW'(K - 1)) state_d = ENC;
      ENC:  if (i_cnt == '0) state_d = OUT;
      OUT:  if (bus.cw_ack) state_d = (words_left == 8'd1) ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m          <= '0;
      i_cnt      <= '0;
      w_cnt      <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      cw_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          words_left <= bus.num_words;
          bit_cnt    <= '0;
        end
        LOAD: if (take) begin
          m <= MW'({cur_bit, m[K-1:0]} >> 1);
          if (bit_cnt == BW'(K - 1)) begin
            bit_cnt <= '0;
            i_cnt   <= IW'(N - 1);
            w_cnt   <= WW'(W);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ENC: begin
          cw_q[i_cnt] <= enc_one;
          if (enc_one) begin
            m     <= m - coef;
            w_cnt <= w_cnt - 1'b1;
          end
          i_cnt <= i_cnt - 1'b1;
        end
        OUT: if (bus.cw_ack) words_left <= words_left - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.cw_out  = cw_q;
  assign bus.cw_rdy  = (state_q == OUT);
  assign bus.cw_done = (state_q == DONE);
  assign bus.busy    = (state_q == LOAD) || (state_q == ENC) || (state_q == OUT);
  assign bus.wr_full = full;

`ifdef CW_WEIGHT_CHECK_EN
  logic [N-1:0] cw_d;
  logic         weight_err_q;

  always_comb begin
    cw_d = cw_q;
    if (state_q == ENC) cw_d[i_cnt] = enc_one;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) weight_err_q <= 1'b0;
    else        weight_err_q <= (state_d == OUT) && (32'($countones(cw_d)) != W);
  end

  assign bus.weight_err = weight_err_q;
`endif
endmodule

// File: tb/tb_cw_stream_encoder.sv
// Directed and randomized checks of cw_stream_encoder against a bit-queue / ranked-codeword model.
module tb_cw_stream_encoder;
  localparam int N  = 18;
  localparam int W  = 9;
  localparam int K  = 15;
  localparam int BW = 8;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cw_stream_encoder_if #(.N(N), .BYTE_W(BW)) bus ();

  cw_stream_encoder #(.N(N), .W(W), .K(K), .BYTE_W(BW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit bq[$];
  int written  = 0;
  int consumed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m-th smallest N-bit value with exactly W ones, stepped with Gosper's next-permutation trick.
  function automatic logic [N-1:0] ref_cw(input longint unsigned m);
    longint unsigned x, c, r;
    x = (64'd1 << W) - 1;
    for (longint unsigned s = 0; s < m; s++) begin
      c = x & (~x + 1);
      r = x + c;
      x = (((r ^ x) >> 2) / c) | r;
    end
    return N'(x);
  endfunction

  function automatic longint unsigned next_m();
    longint unsigned m;
    m = 0;
    for (int j = 0; j < K; j++) if (bq.size() > 0 && bq.pop_front()) m |= (64'd1 << j);
    consumed += K;
    return m;
  endfunction

  task automatic model_clear();
    bq.delete();
    written  = 0;
    consumed = 0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    int occ;
    occ = written - (consumed + 7) / 8;
    bus.msg_byte = b;
    bus.wr_en    = 1'b1;
    tick();
    bus.wr_en    = 1'b0;
    if (occ < FD) begin
      for (int j = 0; j < BW; j++) bq.push_back(b[j]);
      written++;
    end
  endtask

  task automatic refill();
    int occ, need, space, n;
    occ   = written - (consumed + 7) / 8;
    need  = (bq.size() >= K) ? 0 : (K - bq.size() + 7) / 8;
    space = FD - occ;
    n = (need >= space) ? space : int'($urandom_range(space, need));
    for (int j = 0; j < n; j++) write_byte(8'($urandom));
  endtask

  task automatic start_job(input int nw);
    bus.num_words = 8'(nw);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (bus.cw_rdy !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    check("rdy_timeout", 64'(bus.cw_rdy), 64'd1);
  endtask

  task automatic expect_word(input string tag, output logic [N-1:0] exp);
    exp = ref_cw(next_m());
    check(tag, 64'(bus.cw_out), 64'(exp));
    check({tag, "_weight"}, 64'($countones(bus.cw_out)), 64'(W));
`ifdef CW_WEIGHT_CHECK_EN
    check({tag, "_werr"}, 64'(bus.weight_err), 64'd0);
`endif
  endtask

  task automatic ack_word(input bit last);
    bus.cw_ack = 1'b1;
    tick();
    bus.cw_ack = 1'b0;
    check("done_after_ack", 64'(bus.cw_done), 64'(last));
    check("busy_after_ack", 64'(bus.busy), 64'(!last));
  endtask

  initial begin
    logic [N-1:0] exp;
    int lat, nw, hold, dcnt;
    bus.start = 1'b0; bus.num_words = '0; bus.msg_byte = '0;
    bus.wr_en = 1'b0; bus.cw_ack = 1'b0;

    #12;
    check("rst_cw_out", 64'(bus.cw_out), 64'd0);
    check("rst_cw_rdy", 64'(bus.cw_rdy), 64'd0);
    check("rst_cw_done", 64'(bus.cw_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_wr_full", 64'(bus.wr_full), 64'd0);
    rst_b = 1'b1;
    tick();

    // all-zero message, latency from first available bit
    write_byte(8'h00); write_byte(8'h00);
    start_job(1);
    wait_rdy(lat);
    check("latency", 64'(lat), 64'(K + N));
    check("busy_out", 64'(bus.busy), 64'd1);
    check("zero_const", 64'(bus.cw_out), 64'h001FF);
    expect_word("zero_model", exp);
    ack_word(1'b1);
    tick();
    check("done_one_cycle", 64'(bus.cw_done), 64'd0);

    do_reset();
    write_byte(8'h01); write_byte(8'h00);
    start_job(1);
    wait_rdy(lat);
    check("one_const", 64'(bus.cw_out), 64'h002FF);
    expect_word("one_model", exp);
    ack_word(1'b1);

    do_reset();
    write_byte(8'hFF); write_byte(8'h7F);
    start_job(1);
    wait_rdy(lat);
    expect_word("max_m", exp);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_cw_out", 64'(bus.cw_out), 64'(exp));
      check("hold_cw_rdy", 64'(bus.cw_rdy), 64'd1);
    end
    ack_word(1'b1);

    // stall in LOAD until more bytes arrive
    do_reset();
    write_byte(8'($urandom)); write_byte(8'($urandom));
    start_job(3);
    wait_rdy(lat);
    expect_word("stall_w1", exp);
    ack_word(1'b0);
    repeat (20) tick();
    check("stall_rdy", 64'(bus.cw_rdy), 64'd0);
    check("stall_busy", 64'(bus.busy), 64'd1);
    for (int j = 0; j < 4; j++) write_byte(8'($urandom));
    wait_rdy(lat);
    expect_word("stall_w2", exp);
    ack_word(1'b0);
    wait_rdy(lat);
    expect_word("stall_w3", exp);
    dcnt = 0;
    bus.cw_ack = 1'b1;
    tick();
    bus.cw_ack = 1'b0;
    if (bus.cw_done === 1'b1) dcnt++;
    repeat (5) begin
      tick();
      if (bus.cw_done === 1'b1) dcnt++;
    end
    check("single_done", 64'(dcnt), 64'd1);

    // FIFO overflow and empty job
    do_reset();
    for (int j = 0; j < 5; j++) begin
      write_byte(8'($urandom));
      check("wr_full", 64'(bus.wr_full), 64'(j >= 3));
    end
    start_job(0);
    check("zero_job_done", 64'(bus.cw_done), 64'd1);
    check("zero_job_busy", 64'(bus.busy), 64'd0);
    tick();
    check("zero_job_done_end", 64'(bus.cw_done), 64'd0);
    start_job(2);
    wait_rdy(lat);
    expect_word("after_drop_w1", exp);
    ack_word(1'b0);
    wait_rdy(lat);
    expect_word("after_drop_w2", exp);
    ack_word(1'b1);

    // asynchronous reset during ENC with bytes still queued
    do_reset();
    for (int j = 0; j < 4; j++) write_byte(8'($urandom));
    start_job(1);
    repeat (K + 5) tick();
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst_b = 1'b0;
    #1;
    check("arst_cw_out", 64'(bus.cw_out), 64'd0);
    check("arst_cw_rdy", 64'(bus.cw_rdy), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_wr_full", 64'(bus.wr_full), 64'd0);
    tick();
    rst_b = 1'b1;
    model_clear();
    dcnt = 0;
    repeat (4) begin
      tick();
      if (bus.cw_done === 1'b1) dcnt++;
    end
    check("arst_no_done", 64'(dcnt), 64'd0);
    write_byte(8'($urandom)); write_byte(8'($urandom));
    start_job(1);
    wait_rdy(lat);
    expect_word("post_rst", exp);
    ack_word(1'b1);

    // randomized jobs with carry-over bits and ack back-pressure
    for (int job = 0; job < 8; job++) begin
      nw = int'($urandom_range(4, 1));
      refill();
      start_job(nw);
      for (int j = 0; j < nw; j++) begin
        wait_rdy(lat);
        expect_word("rand_word", exp);
        hold = int'($urandom_range(3, 0));
        repeat (hold) begin
          tick();
          check("rand_hold", 64'(bus.cw_out), 64'(exp));
        end
        refill();
        ack_word(j == nw - 1);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
